udp_pkt_tx_mux: RTL and testbench
=================================

# udp_pkt_tx_mux

Transmit-side counterpart of the UDP packet router. It arbitrates round-robin among P_NUM_PORTS first-word-fall-through (FWFT) payload sources and builds each packet:

- prepends the 8-byte UDP header (source port, destination port, length, checksum = 0x0000);
- emits the packet as a FWFT byte stream to the IPv4 transmit packet builder.

It also enforces declared payload lengths, padding short packets and dropping oversize ones.

## Interface
Parameters:
- P_NUM_PORTS, 3, number of payload sources
- P_SRC_PORTS, {16'd10000, 16'd12000, 16'd14000}, [0:P_NUM_PORTS-1][15:0] UDP source port per index
- P_DEST_PORTS, {16'd10000, 16'd12000, 16'd14000}, [0:P_NUM_PORTS-1][15:0] UDP destination port per index
- P_MAX_PAYLOAD, 1472, largest accepted payload in bytes

Ports (one clock; reset is asynchronous and active-low):
- i_txmac_clk  in  1  clock
- i_txmac_arst_n  in  1  asynchronous active-low reset
- i_port_byte  in  [0:P_NUM_PORTS-1][7:0]  source payload byte (FWFT)
- i_port_byte_vld  in  [0:P_NUM_PORTS-1]  source byte valid
- i_port_last_byte  in  [0:P_NUM_PORTS-1]  marks final payload byte
- i_port_pkt_len  in  [0:P_NUM_PORTS-1][15:0]  payload length; valid with first byte, held until last byte popped
- o_port_byte_rd  out  [0:P_NUM_PORTS-1]  pop strobe to source
- o_udp_pkt_byte  out  8  UDP packet byte (FWFT)
- o_udp_pkt_byte_vld  out  1  output byte valid
- o_udp_pkt_last_byte  out  1  final byte of UDP packet
- i_udp_pkt_byte_rd  in  1  downstream pop
- o_udp_pkt_len  out  16  UDP length (payload+8); stable from first header byte to last byte
- o_len_err  out  1  one-cycle pulse on length mismatch or oversize drop

## Operation
- States: IDLE, HDR, PAYLOAD, PAD, DRAIN.
- **IDLE**
  - Any i_port_byte_vld set: grant the first requesting index after the previous grant (round-robin) and latch its i_port_pkt_len into a 16-bit len register.
  - Oversize (len > P_MAX_PAYLOAD): go to DRAIN and pulse o_len_err.
  - Otherwise go to HDR.
- **HDR**
  - Emits 8 bytes from registers: src[15:8], src[7:0], dest[15:8], dest[7:0], (len+8)[15:8], (len+8)[7:0], 0x00, 0x00.
  - o_udp_pkt_byte_vld=1 throughout. Index advances on each cycle with i_udp_pkt_byte_rd=1.
  - After byte 7 is popped:
    - len==0 (header-only packet): o_udp_pkt_last_byte is asserted on byte 7; go to IDLE.
    - Otherwise go to PAYLOAD.
- **PAYLOAD**
  - Datapath is combinational from the granted source: o_udp_pkt_byte=i_port_byte[g], o_udp_pkt_byte_vld=i_port_byte_vld[g], o_port_byte_rd[g]=i_udp_pkt_byte_rd & i_port_byte_vld[g].
  - A down-counter starts at len and decrements per pop. o_udp_pkt_last_byte=1 when counter==1.
  - Counter==1 popped and source last_byte also set: go to IDLE.
  - Counter==1 popped without source last_byte: pulse o_len_err; go to DRAIN.
  - Source last_byte popped with counter>1: pulse o_len_err; go to PAD.
- **PAD**
  - Emits 0x00 bytes until the counter reaches 0. last_byte is asserted on the final pad byte; then go to IDLE.
  - o_port_byte_rd is 0.
- **DRAIN**
  - o_port_byte_rd[g]=i_port_byte_vld[g]; nothing is emitted (vld=0).
  - Exit to IDLE after the source's last_byte is popped.
- o_port_byte_rd for non-granted indices is always 0.

## Timing
- Reset values:
  - All outputs are 0 and the state is IDLE.
  - The round-robin pointer resets to P_NUM_PORTS-1, so index 0 wins first.
  - Reset mid-packet abandons the packet immediately. No residue is drained after reset.
- Latency:
  - First header byte is valid the cycle after IDLE samples a request.
  - After a last-byte pop, at least one IDLE cycle occurs before the next header.
- Handshake:
  - A byte transfers on a clock edge where o_udp_pkt_byte_vld & i_udp_pkt_byte_rd.
  - Data and vld hold while rd=0.
  - In PAYLOAD, source vld low stalls the output (vld low) without leaving the state.
- Simultaneous requests resolve in the same IDLE cycle by round-robin order.
- Arithmetic: len+8 is computed in 16 bits. It cannot wrap because P_MAX_PAYLOAD ≤ 65527 and larger lengths are dropped before HDR.
- o_len_err is registered and asserts the cycle after the triggering pop or decision.

## Test plan
- **Basic packet**
  - Stimulus: port 0 sends 16-byte payload 0x01..0x10, rd held 1.
  - Required response: bytes 27 10 27 10 00 18 00 00 then 01..10; last_byte on byte 24; o_udp_pkt_len=24; no o_len_err.
- **Round-robin**
  - Stimulus: ports 0, 1 and 2 all request at once.
  - Required response: emitted order is 0, 1, 2. Port 1 requesting again after packet 1 is served only after port 2.
- **Header-only and stall**
  - Stimulus: port 2 with len=0, downstream rd toggling 1/0.
  - Required response: exactly 8 bytes, length field 0x0008, last_byte on byte 8, o_port_byte_rd[2] never asserted, no byte duplicated or lost.
- **Short source**
  - Stimulus: len=8, but source last_byte arrives on byte 4 (payload AA BB CC DD).
  - Required response: payload AA BB CC DD 00 00 00 00, o_len_err pulses once.
  - Long-source variant: len=4 with a 6-byte source → 4 bytes emitted, 2 drained silently, one o_len_err pulse.
- **Oversize**
  - Stimulus: len=1500.
  - Required response: no output bytes, all 1500 source bytes popped, one o_len_err pulse; the next 4-byte packet is emitted correctly.
- **Reset mid-packet**
  - Stimulus: assert i_txmac_arst_n low during PAYLOAD.
  - Required response: all outputs 0 asynchronously; after release, port 0 wins the first grant.

Source files
------------

// File: rtl/udp_pkt_tx_mux.sv
// UDP transmit mux: round-robin arbitration over FWFT payload sources, prepends the
// 8-byte UDP header and enforces declared payload lengths (pad short, drop oversize).
module udp_pkt_tx_mux #(
  parameter int                             P_NUM_PORTS   = 3,
  parameter logic [0:P_NUM_PORTS-1][15:0]   P_SRC_PORTS   = {16'd10000, 16'd12000, 16'd14000},
  parameter logic [0:P_NUM_PORTS-1][15:0]   P_DEST_PORTS  = {16'd10000, 16'd12000, 16'd14000},
  parameter int                             P_MAX_PAYLOAD = 1472
) (
  input  logic                             i_txmac_clk,
  input  logic                             i_txmac_arst_n,
  input  logic [0:P_NUM_PORTS-1][7:0]      i_port_byte,
  input  logic [0:P_NUM_PORTS-1]           i_port_byte_vld,
  input  logic [0:P_NUM_PORTS-1]           i_port_last_byte,
  input  logic [0:P_NUM_PORTS-1][15:0]     i_port_pkt_len,
  output logic [0:P_NUM_PORTS-1]           o_port_byte_rd,
  output logic [7:0]                       o_udp_pkt_byte,
  output logic                             o_udp_pkt_byte_vld,
  output logic                             o_udp_pkt_last_byte,
  input  logic                             i_udp_pkt_byte_rd,
  output logic [15:0]                      o_udp_pkt_len,
  output logic                             o_len_err
);

  localparam int          PW      = (P_NUM_PORTS > 1) ? $clog2(P_NUM_PORTS) : 1;
  localparam logic [15:0] MAX_LEN = 16'(P_MAX_PAYLOAD);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_PAD, S_DRAIN} state_t;

  state_t        state;
  logic [PW-1:0] grant;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] next_grant;
  logic [2:0]    hdr_idx;
  logic [15:0]   cnt;
  logic [7:0]    hdr_byte;
  logic          src_pop;
  int            cand;

  // Walk from the farthest offset to the nearest so the first requester after rr_ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_grant = rr_ptr;
    cand       = 0;
    for (int i = P_NUM_PORTS; i >= 1; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= P_NUM_PORTS) cand = cand - P_NUM_PORTS;
      if (i_port_byte_vld[cand]) next_grant = PW'(cand);
    end
  end

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      3'd0:    hdr_byte = P_SRC_PORTS[grant][15:8];
      3'd1:    hdr_byte = P_SRC_PORTS[grant][7:0];
      3'd2:    hdr_byte = P_DEST_PORTS[grant][15:8];
      3'd3:    hdr_byte = P_DEST_PORTS[grant][7:0];
      3'd4:    hdr_byte = o_udp_pkt_len[15:8];
      3'd5:    hdr_byte = o_udp_pkt_len[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  assign src_pop = i_udp_pkt_byte_rd & i_port_byte_vld[grant];

  always_comb begin
    o_udp_pkt_byte      = 8'h00;
    o_udp_pkt_byte_vld  = 1'b0;
    o_udp_pkt_last_byte = 1'b0;
    o_port_byte_rd      = '0;
    case (state)
      S_HDR: begin
        o_udp_pkt_byte      = hdr_byte;
        o_udp_pkt_byte_vld  = 1'b1;
        o_udp_pkt_last_byte = (hdr_idx == 3'd7) && (cnt == 16'd0);
      end
      S_PAYLOAD: begin
        o_udp_pkt_byte        = i_port_byte[grant];
        o_udp_pkt_byte_vld    = i_port_byte_vld[grant];
        o_udp_pkt_last_byte   = (cnt == 16'd1);
        o_port_byte_rd[grant] = src_pop;
      end
      S_PAD: begin
        o_udp_pkt_byte_vld  = 1'b1;
        o_udp_pkt_last_byte = (cnt == 16'd1);
      end
      S_DRAIN: o_port_byte_rd[grant] = i_port_byte_vld[grant];
      default: ;
    endcase
  end

  // cnt holds the declared length through the header, then counts payload bytes down.
  always_ff @(posedge i_txmac_clk or negedge i_txmac_arst_n) begin
    if (!i_txmac_arst_n) begin
      state         <= S_IDLE;
      grant         <= '0;
      rr_ptr        <= PW'(P_NUM_PORTS - 1);
      hdr_idx       <= 3'd0;
      cnt           <= 16'd0;
      o_udp_pkt_len <= 16'd0;
      o_len_err     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      o_len_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|i_port_byte_vld) begin
            grant   <= next_grant;
            rr_ptr  <= next_grant;
            cnt     <= i_port_pkt_len[next_grant];
            hdr_idx <= 3'd0;
            if (i_port_pkt_len[next_grant] > MAX_LEN) begin
              state     <= S_DRAIN;
              o_len_err <= 1'b1;
            end else begin
              state         <= S_HDR;
              o_udp_pkt_len <= i_port_pkt_len[next_grant] + 16'd8;
            end
          end
        end
        S_HDR: begin
          if (i_udp_pkt_byte_rd) begin
            hdr_idx <= hdr_idx + 3'd1;
            if (hdr_idx == 3'd7) state <= (cnt == 16'd0) ? S_IDLE : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (src_pop) begin
            cnt <= cnt - 16'd1;
            if (cnt == 16'd1) begin
              if (i_port_last_byte[grant]) begin
                state <= S_IDLE;
              end else begin
                state     <= S_DRAIN;
                o_len_err <= 1'b1;
              end
            end else if (i_port_last_byte[grant]) begin
              state     <= S_PAD;
              o_len_err <= 1'b1;
            end
          end
        end
        S_PAD: begin
          if (i_udp_pkt_byte_rd) begin
            cnt <= cnt - 16'd1;
            if (cnt == 16'd1) state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (i_port_byte_vld[grant] && i_port_last_byte[grant]) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_pkt_tx_mux.sv
// Bench for udp_pkt_tx_mux: per-port source queues, a packet-level reference model
// that predicts the byte stream in round-robin order, directed vectors and a random run.
module tb_udp_pkt_tx_mux;

  localparam int NP   = 3;
  localparam int MAXP = 1472;
  localparam int SRC_P [NP] = '{10000, 12000, 14000};
  localparam int DST_P [NP] = '{10000, 12000, 14000};

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [0:NP-1][7:0]    port_byte;
  logic [0:NP-1]         port_vld;
  logic [0:NP-1]         port_last;
  logic [0:NP-1][15:0]   port_len;
  logic [0:NP-1]         port_rd;
  logic [7:0]            udp_byte;
  logic                  udp_vld;
  logic                  udp_last;
  logic                  udp_rd;
  logic [15:0]           udp_len;
  logic                  len_err;

  always #5 clk = ~clk;

  udp_pkt_tx_mux dut (
    .i_txmac_clk        (clk),
    .i_txmac_arst_n     (rst_n),
    .i_port_byte        (port_byte),
    .i_port_byte_vld    (port_vld),
    .i_port_last_byte   (port_last),
    .i_port_pkt_len     (port_len),
    .o_port_byte_rd     (port_rd),
    .o_udp_pkt_byte     (udp_byte),
    .o_udp_pkt_byte_vld (udp_vld),
    .o_udp_pkt_last_byte(udp_last),
    .i_udp_pkt_byte_rd  (udp_rd),
    .o_udp_pkt_len      (udp_len),
    .o_len_err          (len_err)
  );

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic [15:0] len;
    logic        zero;
    logic        first;
  } src_t;

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic [15:0] plen;
    logic [1:0]  port;
    logic        zero_end;
  } exp_t;

  typedef struct {
    int len;
    int n;
    int base;
    int step;
  } desc_t;

  typedef struct {
    string name;
    int    port;
    int    len;
    int    n;
    int    base;
    int    step;
    int    rd_mode;
    int    exp_bytes;
    int    exp_errs;
  } vec_t;

  src_t        srcq [NP][$];
  desc_t       pend [NP][$];
  exp_t        expq [$];
  logic [15:0] got_ports [$];
  bit          pop_f [NP];
  bit          zdrop [NP];
  int          mptr = NP - 1;
  int          exp_err = 0;
  int          errs_seen = 0;
  int          xfers = 0;
  int          checks = 0;
  int          errors = 0;
  int          pos = 0;
  logic [7:0]  prev_byte = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_pkt(input int port, input int len, input int n, input int base, input int step);
    desc_t d;
    d.len = len; d.n = n; d.base = base; d.step = step;
    pend[port].push_back(d);
  endtask

  task automatic clear_model();
    for (int p = 0; p < NP; p++) begin
      srcq[p].delete();
      pend[p].delete();
    end
    expq.delete();
    exp_err = 0;
    pos     = 0;
  endtask

  // Reference model: pick packets round-robin over ports with pending work and expand
  // each into the source bytes it offers and the UDP byte stream it must produce.
  task automatic build();
    desc_t       d;
    logic [7:0]  b [$];
    logic [7:0]  h [8];
    logic [15:0] plen, sp, dp;
    int          p;
    while (pend[0].size() + pend[1].size() + pend[2].size() > 0) begin
      p = -1;
      for (int k = 1; k <= NP; k++)
        if (p < 0 && pend[(mptr + k) % NP].size() > 0) p = (mptr + k) % NP;
      mptr = p;
      d = pend[p].pop_front();
      b.delete();
      for (int i = 0; i < d.n; i++)
        b.push_back((d.base < 0) ? 8'($urandom) : 8'(d.base + i * d.step));
      if (d.n == 0)
        srcq[p].push_back('{data: 8'h00, last: 1'b0, len: 16'(d.len), zero: 1'b1, first: 1'b1});
      for (int i = 0; i < d.n; i++)
        srcq[p].push_back('{data: b[i], last: (i == d.n - 1), len: 16'(d.len), zero: 1'b0, first: (i == 0)});
      if (d.len > MAXP) begin
        exp_err++;
      end else begin
        plen = 16'(d.len + 8);
        sp   = 16'(SRC_P[p]);
        dp   = 16'(DST_P[p]);
        h[0] = sp[15:8];   h[1] = sp[7:0];
        h[2] = dp[15:8];   h[3] = dp[7:0];
        h[4] = plen[15:8]; h[5] = plen[7:0];
        h[6] = 8'h00;      h[7] = 8'h00;
        for (int k = 0; k < 8; k++)
          expq.push_back('{data: h[k], last: (d.len == 0 && k == 7), plen: plen,
                           port: 2'(p), zero_end: (d.n == 0 && k == 7)});
        for (int i = 0; i < d.len; i++)
          expq.push_back('{data: (i < d.n) ? b[i] : 8'h00, last: (i == d.len - 1), plen: plen,
                           port: 2'(p), zero_end: 1'b0});
        if (d.len > 0 && d.n != d.len) exp_err++;
      end
    end
  endtask

  task automatic drive(input int rd_mode, input int cyc);
    src_t f;
    for (int p = 0; p < NP; p++) begin
      if (srcq[p].size() > 0) begin
        f = srcq[p][0];
        port_vld[p]  = f.zero || f.first || (rd_mode != 2) || ($urandom_range(0, 3) != 0);
        port_byte[p] = f.data;
        port_last[p] = f.last;
        port_len[p]  = f.len;
      end else begin
        port_vld[p]  = 1'b0;
        port_byte[p] = 8'h00;
        port_last[p] = 1'b0;
        port_len[p]  = 16'h0000;
      end
    end
    case (rd_mode)
      0:       udp_rd = 1'b1;
      1:       udp_rd = (cyc % 2 == 0);
      default: udp_rd = ($urandom_range(0, 9) < 7);
    endcase
  endtask

  task automatic sample();
    exp_t e;
    bit   ok;
    for (int p = 0; p < NP; p++) begin
      pop_f[p] = 1'b0;
      zdrop[p] = 1'b0;
    end
    for (int p = 0; p < NP; p++) begin
      if (port_rd[p]) begin
        ok = (srcq[p].size() > 0) && !srcq[p][0].zero && port_vld[p];
        check("src_pop_legal", 64'(ok), 64'd1);
        if (ok) pop_f[p] = 1'b1;
      end
    end
    if (udp_vld && udp_rd) begin
      xfers++;
      check("xfer_expected", 64'(expq.size() > 0), 64'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("out_byte", 64'({udp_byte, udp_last, udp_len}), 64'({e.data, e.last, e.plen}));
        if (e.zero_end) zdrop[int'(e.port)] = 1'b1;
      end
      if (pos == 1) got_ports.push_back({prev_byte, udp_byte});
      prev_byte = udp_byte;
      pos       = udp_last ? 0 : pos + 1;
    end
    if (len_err) errs_seen++;
  endtask

  task automatic run(input int max_cycles, input bit must_finish, input int rd_mode);
    int cyc   = 0;
    int quiet = 0;
    bit done;
    xfers     = 0;
    errs_seen = 0;
    while (1) begin
      drive(rd_mode, cyc);
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++)
        if (pop_f[p] || zdrop[p]) void'(srcq[p].pop_front());
      cyc++;
      done = (expq.size() == 0) && (srcq[0].size() + srcq[1].size() + srcq[2].size() == 0);
      quiet = done ? quiet + 1 : 0;
      if (quiet >= 4) break;
      if (cyc >= max_cycles) begin
        if (must_finish) begin
          check("run_complete", 64'(done), 64'd1);
          clear_model();
        end
        break;
      end
    end
    if (must_finish) check("len_err_count", 64'(errs_seen), 64'(exp_err));
    exp_err = 0;
  endtask

  task automatic idle_inputs();
    port_vld  = '0;
    port_byte = '0;
    port_last = '0;
    port_len  = '0;
    udp_rd    = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [6];
    logic [15:0] rr_exp [4];
    int          p, len, n;

    vecs[0] = '{"basic",          0,   16,   16,    1,    1, 0, 24, 0};
    vecs[1] = '{"hdr_only",       2,    0,    0,    0,    0, 1,  8, 0};
    vecs[2] = '{"short_src",      1,    8,    4, 'hAA, 'h11, 0, 16, 1};
    vecs[3] = '{"long_src",       0,    4,    6, 'h10,    1, 0, 12, 1};
    vecs[4] = '{"oversize",       1, 1500, 1500,    0,    1, 0,  0, 1};
    vecs[5] = '{"after_oversize", 1,    4,    4, 'h40,    1, 2, 12, 0};
    rr_exp  = '{16'd10000, 16'd12000, 16'd14000, 16'd12000};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({udp_byte, udp_vld, udp_last, udp_len, len_err, port_rd}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Simultaneous requests right after reset, port 1 queued twice.
    got_ports.delete();
    add_pkt(0, 3, 3, 'h30, 1);
    add_pkt(1, 5, 5, 'h50, 1);
    add_pkt(2, 2, 2, 'h70, 1);
    add_pkt(1, 4, 4, 'h90, 1);
    build();
    run(2000, 1'b1, 0);
    check("rr_count", 64'(got_ports.size()), 64'd4);
    for (int k = 0; k < 4 && k < got_ports.size(); k++)
      check("rr_order", 64'(got_ports[k]), 64'(rr_exp[k]));

    foreach (vecs[i]) begin
      add_pkt(vecs[i].port, vecs[i].len, vecs[i].n, vecs[i].base, vecs[i].step);
      build();
      run(8000, 1'b1, vecs[i].rd_mode);
      check({vecs[i].name, "_bytes"}, 64'(xfers), 64'(vecs[i].exp_bytes));
      check({vecs[i].name, "_errs"}, 64'(errs_seen), 64'(vecs[i].exp_errs));
    end

    for (int i = 0; i < 40; i++) begin
      p   = $urandom_range(0, NP - 1);
      len = $urandom_range(0, 20);
      n   = (len == 0) ? 0 : (($urandom_range(0, 9) < 7) ? len : $urandom_range(1, 24));
      add_pkt(p, len, n, -1, 0);
    end
    build();
    run(20000, 1'b1, 2);

    // Reset in the middle of a port 1 payload; afterwards port 0 must win over port 2.
    add_pkt(1, 30, 30, 'h01, 3);
    build();
    run(20, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", 64'({udp_byte, udp_vld, udp_last, udp_len, len_err, port_rd}), 64'd0);
    clear_model();
    idle_inputs();
    mptr = NP - 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_ports.delete();
    add_pkt(2, 3, 3, 'hC0, 1);
    add_pkt(0, 3, 3, 'hA0, 1);
    build();
    run(2000, 1'b1, 0);
    check("post_reset_count", 64'(got_ports.size()), 64'd2);
    if (got_ports.size() > 0) check("post_reset_first", 64'(got_ports[0]), 64'd10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
